// File: rtl/fp_axis_issuer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_axis_issuer : AXI4-Stream operand issuer / credit-protected result FIFO
//                  for clk/ce-wrapped floating-point operator cores.
// Revision 1.0
// ---------------------------------------------------------------------------
module fp_axis_issuer #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic              m_axis_a_tvalid,
   input  logic              m_axis_a_tready,
   output logic [DATA_W-1:0] m_axis_a_tdata,
   output logic              m_axis_b_tvalid,
   input  logic              m_axis_b_tready,
   output logic [DATA_W-1:0] m_axis_b_tdata,
   input  logic              s_axis_result_tvalid,
   output logic              s_axis_result_tready,
   input  logic [DATA_W-1:0] s_axis_result_tdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [CNT_W-1:0]  outstanding,
   output logic              err_unexpected
);

   localparam int             PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {CH_IDLE = 1'b0, CH_PEND = 1'b1} ch_state_e;
   typedef enum logic [1:0] {
      PAIR_EMPTY  = 2'b00,
      PAIR_B_ONLY = 2'b01,
      PAIR_A_ONLY = 2'b10,
      PAIR_BOTH   = 2'b11
   } pair_state_e;

   ch_state_e           a_state_q, a_state_d, b_state_q, b_state_d;
   pair_state_e         pair_state;
   logic [DATA_W-1:0]   a_data_q, a_data_d, b_data_q, b_data_d;
   logic [CNT_W-1:0]    out_q, out_d;
   logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

   logic fifo_empty, fifo_full, req_fire, push, pop, pop_credit;

   assign pair_state = pair_state_e'({a_state_q == CH_PEND, b_state_q == CH_PEND});
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   // No bypass: a new pair is only taken once both channels have drained.
   assign req_ready  = (pair_state == PAIR_EMPTY) && (out_q < DEPTH_C);
   assign req_fire   = req_valid && req_ready;
   assign push       = s_axis_result_tvalid && s_axis_result_tready;
   assign pop        = rsp_valid && rsp_ready;
   // An unexpected beat carries no credit, so popping it must not underflow.
   assign pop_credit = pop && (out_q != '0);

   assign m_axis_a_tvalid      = (a_state_q == CH_PEND);
   assign m_axis_b_tvalid      = (b_state_q == CH_PEND);
   assign m_axis_a_tdata       = a_data_q;
   assign m_axis_b_tdata       = b_data_q;
   assign s_axis_result_tready = !fifo_full;
   assign rsp_valid            = !fifo_empty;
   assign rsp_data             = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign outstanding          = out_q;
   assign err_unexpected       = err_q;

   always_comb begin
      a_state_d = a_state_q;
      b_state_d = b_state_q;
      a_data_d  = a_data_q;
      b_data_d  = b_data_q;
      out_d     = out_q;
      err_d     = err_q;
      wr_ptr_d  = wr_ptr_q + {{PTR_W{1'b0}}, push};
      rd_ptr_d  = rd_ptr_q + {{PTR_W{1'b0}}, pop};

      if (req_fire) begin
         a_state_d = CH_PEND;
         b_state_d = CH_PEND;
         a_data_d  = req_a;
         b_data_d  = req_b;
      end else begin
         if (a_state_q == CH_PEND && m_axis_a_tready) a_state_d = CH_IDLE;
         if (b_state_q == CH_PEND && m_axis_b_tready) b_state_d = CH_IDLE;
      end

      case ({req_fire, pop_credit})
         2'b10:   out_d = out_q + CNT_W'(1);
         2'b01:   out_d = out_q - CNT_W'(1);
         default: out_d = out_q;
      endcase

      if (push && (out_q == '0) && !req_fire) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_state_q <= CH_IDLE;
         b_state_q <= CH_IDLE;
         a_data_q  <= '0;
         b_data_q  <= '0;
         out_q     <= '0;
         err_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         a_state_q <= a_state_d;
         b_state_q <= b_state_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
         out_q     <= out_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage needs no reset; validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= s_axis_result_tdata;
   end

endmodule
`default_nettype wire
